// File: rtl/offset_strip_pipe.sv
// Three-stage valid/ready pipeline that strips the forward chain's constant offsets (-OFF0, -OFF1, -OFF2).
// Optional underflow tracking is enabled by defining OFFSET_STRIP_UFLOW_CHK_EN.
module offset_strip_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OFF0  = 10,
  parameter int unsigned OFF1  = 3,
  parameter int unsigned OFF2  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_uflow,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam logic [WIDTH-1:0] K0 = WIDTH'(OFF0);
  localparam logic [WIDTH-1:0] K1 = WIDTH'(OFF1);
  localparam logic [WIDTH-1:0] K2 = WIDTH'(OFF2);

  logic             r_v1, r_v2, r_v3;
  logic [WIDTH-1:0] r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt;

  logic w_adv3, w_rdy3, w_rdy2, w_rdy1;

  // Each stage may accept whenever it is empty or everything downstream of it moves.
  assign w_adv3 = r_v3 & out_ready;
  assign w_rdy3 = ~r_v3 | out_ready;
  assign w_rdy2 = ~r_v2 | w_rdy3;
  assign w_rdy1 = ~r_v1 | w_rdy2;

  assign in_ready  = w_rdy1;
  assign out_valid = r_v3;
  assign out_data  = r_s3;
  assign pass_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_rdy1) begin
        r_v1 <= in_valid;
        if (in_valid) r_s1 <= in_data - K0;
      end
      if (w_rdy2) begin
        r_v2 <= r_v1;
        if (r_v1) r_s2 <= r_s1 - K1;
      end
      if (w_rdy3) begin
        r_v3 <= r_v2;
        if (r_v2) r_s3 <= r_s2 - K2;
      end
      if (w_adv3 && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef OFFSET_STRIP_UFLOW_CHK_EN
  logic r_u1, r_u2, r_u3;
  logic w_b1, w_b2, w_b3;

  // Sticky borrow flag follows its word through the same enables as the data.
  assign w_b1 = (in_data < K0);
  assign w_b2 = (r_s1 < K1);
  assign w_b3 = (r_s2 < K2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_u1 <= 1'b0;
      r_u2 <= 1'b0;
      r_u3 <= 1'b0;
    end else begin
      if (w_rdy1 && in_valid) r_u1 <= w_b1;
      if (w_rdy2 && r_v1)     r_u2 <= r_u1 | w_b2;
      if (w_rdy3 && r_v2)     r_u3 <= r_u2 | w_b3;
    end
  end

  assign out_uflow = r_u3;
`else
  assign out_uflow = 1'b0;
`endif

endmodule
